rr_edge_event_arbiter: RTL and testbench

//  Multi-channel edge-event collector with per-channel pending counters and a

---
 rtl/rr_edge_event_arbiter_if.sv | 13 +
 rtl/rr_edge_event_arbiter.sv | 132 +++++++++++++
 tb/tb_rr_edge_event_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/rr_edge_event_arbiter_if.sv
// Event delivery channel: the arbiter drives index/valid and the consumer drives ready.
interface rr_edge_event_arbiter_if #(
   parameter int DATA_WIDTH = 8
);
   localparam int LB_DATA_WIDTH = $clog2(DATA_WIDTH);

   logic [LB_DATA_WIDTH-1:0] index;
   logic                     valid;
   logic                     ready;

   modport master (output index, output valid, input ready);
   modport slave  (input index, input valid, output ready);
endinterface

// File: rtl/rr_edge_event_arbiter.sv
// Multi-channel edge-event collector: synchronise, detect edges, count pending events
// per channel and deliver channel indices one per valid/ready handshake in round-robin order.
module rr_edge_event_arbiter #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2,
   parameter int PEND_WIDTH  = 3
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [DATA_WIDTH-1:0]   in_data,
   input  logic [DATA_WIDTH-1:0]   chan_en,
   input  logic [1:0]              edge_mode,
   input  logic                    clr_overflow,
   rr_edge_event_arbiter_if.master evt,
   output logic [DATA_WIDTH-1:0]   overflow
);
   localparam int LB_DATA_WIDTH = $clog2(DATA_WIDTH);
   localparam int WARM_W        = $clog2(SYNC_STAGES + 2);
   localparam logic [WARM_W-1:0]     WARM_INIT = WARM_W'(SYNC_STAGES + 1);
   localparam logic [PEND_WIDTH-1:0] PEND_MAX  = '1;

   logic [DATA_WIDTH-1:0]    sync_q [SYNC_STAGES];
   logic [DATA_WIDTH-1:0]    prev_q;
   logic [WARM_W-1:0]        warm_cnt;
   logic                     warmup;
   logic [DATA_WIDTH-1:0]    s, rise, fall, sel, ev, dec, eff, ovf_set;
   logic [PEND_WIDTH-1:0]    pend [DATA_WIDTH];
   logic [LB_DATA_WIDTH-1:0] index_q, ptr, nxt_ptr, start, winner;
   logic                     valid_q, xfer, found;
   logic [LB_DATA_WIDTH:0]   jw;

   assign evt.index = index_q;
   assign evt.valid = valid_q;

   // Synchroniser chain plus one-cycle delayed copy for edge detection
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
         prev_q   <= '0;
         warm_cnt <= WARM_INIT;
      end else begin
         sync_q[0] <= in_data;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
         prev_q <= sync_q[SYNC_STAGES-1];
         if (warmup) warm_cnt <= warm_cnt - WARM_W'(1);
      end
   end

   assign warmup = (warm_cnt != '0);
   assign s      = sync_q[SYNC_STAGES-1];
   assign rise   = s & ~prev_q;
   assign fall   = ~s & prev_q;

   always_comb begin
      sel = '0;
      case (edge_mode)
         2'b01:   sel = rise;
         2'b10:   sel = fall;
         2'b11:   sel = rise | fall;
         default: sel = '0;
      endcase
   end

   assign ev   = chan_en & sel & {DATA_WIDTH{~warmup}};
   assign xfer = valid_q & evt.ready;

   // Eligibility ignores events arriving this cycle; a channel draining its last event drops out
   always_comb begin
      dec     = '0;
      eff     = '0;
      ovf_set = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         dec[i]     = xfer && (index_q == LB_DATA_WIDTH'(i));
         eff[i]     = (pend[i] != PEND_WIDTH'(dec[i]));
         ovf_set[i] = ev[i] && !dec[i] && (pend[i] == PEND_MAX);
      end
   end

   // Pending counters and sticky overflow (a new drop outranks a same-cycle clear)
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DATA_WIDTH; i++) pend[i] <= '0;
         overflow <= '0;
      end else begin
         for (int i = 0; i < DATA_WIDTH; i++) begin
            if (ev[i] && !dec[i]) begin
               if (pend[i] != PEND_MAX) pend[i] <= pend[i] + PEND_WIDTH'(1);
            end else if (dec[i] && !ev[i]) begin
               pend[i] <= pend[i] - PEND_WIDTH'(1);
            end
         end
         overflow <= ovf_set | (overflow & ~{DATA_WIDTH{clr_overflow}});
      end
   end

   // On a transfer the search already starts after the channel just served
   assign nxt_ptr = (index_q == LB_DATA_WIDTH'(DATA_WIDTH - 1)) ? '0 : index_q + LB_DATA_WIDTH'(1);
   assign start   = xfer ? nxt_ptr : ptr;

   always_comb begin
      found  = 1'b0;
      winner = start;
      jw     = '0;
      for (int k = 0; k < DATA_WIDTH; k++) begin
         jw = {1'b0, start} + (LB_DATA_WIDTH + 1)'(k);
         if (jw >= (LB_DATA_WIDTH + 1)'(DATA_WIDTH)) jw = jw - (LB_DATA_WIDTH + 1)'(DATA_WIDTH);
         if (!found && eff[jw[LB_DATA_WIDTH-1:0]]) begin
            found  = 1'b1;
            winner = jw[LB_DATA_WIDTH-1:0];
         end
      end
   end

   // Output register: holds while stalled, reloads when empty or consumed
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         index_q <= '0;
         valid_q <= 1'b0;
         ptr     <= '0;
      end else begin
         if (xfer) ptr <= nxt_ptr;
         if (!valid_q || evt.ready) begin
            if (found) begin
               index_q <= winner;
               valid_q <= 1'b1;
            end else begin
               valid_q <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_rr_edge_event_arbiter.sv
// Directed bench for rr_edge_event_arbiter (DATA_WIDTH=8, SYNC_STAGES=2, PEND_WIDTH=3).
`timescale 1ns/1ps
module tb_rr_edge_event_arbiter;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rstn;
   logic [DW-1:0] in_data;
   logic [DW-1:0] chan_en;
   logic [1:0]    edge_mode;
   logic          clr_overflow;
   logic [DW-1:0] overflow;
   int            checks = 0;
   int            errors = 0;
   int            hits, any, stable;

   rr_edge_event_arbiter_if #(.DATA_WIDTH(DW)) bus ();

   rr_edge_event_arbiter #(.DATA_WIDTH(DW), .SYNC_STAGES(2), .PEND_WIDTH(3)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .in_data      (in_data),
      .chan_en      (chan_en),
      .edge_mode    (edge_mode),
      .clr_overflow (clr_overflow),
      .evt          (bus.master),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Samples the output at the current and following negedges; with ready=1 each valid sample is one transfer
   task automatic count_valid(input int n, input logic [2:0] idx, output int h, output int a);
      h = 0;
      a = 0;
      for (int i = 0; i < n; i++) begin
         if (bus.valid === 1'b1) begin
            a++;
            if (bus.index === idx) h++;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      rstn = 1'b0; in_data = '0; chan_en = '1; edge_mode = 2'b01; clr_overflow = 1'b0; bus.ready = 1'b1;
      cyc(2);
      chk("rst_valid", 32'(bus.valid), 0);
      chk("rst_index", 32'(bus.index), 0);
      chk("rst_ovf",   32'(overflow),  0);
      rstn = 1'b1;
      cyc(5);

      // ch1, ch5, ch6 rise together, pointer at 0
      in_data = 8'h62;
      cyc(3); chk("t2_latency_valid", 32'(bus.valid), 0);
      cyc(1); chk("t2_first_valid", 32'(bus.valid), 1); chk("t2_first_idx", 32'(bus.index), 1);
      cyc(1); chk("t2_second_idx", 32'(bus.index), 5);
      cyc(1); chk("t2_third_idx", 32'(bus.index), 6);
      cyc(1); chk("t2_drained", 32'(bus.valid), 0);

      // pointer now 7: ch2 and ch7 together must come out 7 then 2
      in_data = 8'hE6;
      cyc(4); chk("ptr_first_idx", 32'(bus.index), 7); chk("ptr_first_valid", 32'(bus.valid), 1);
      cyc(1); chk("ptr_second_idx", 32'(bus.index), 2);
      cyc(1); chk("ptr_drained", 32'(bus.valid), 0);

      // single rise on ch3: valid after edge 4 for exactly one cycle
      in_data = 8'hEE;
      cyc(3); chk("t1_edge3_valid", 32'(bus.valid), 0);
      cyc(1); chk("t1_edge4_valid", 32'(bus.valid), 1); chk("t1_idx", 32'(bus.index), 3);
      cyc(1); chk("t1_pulse_end", 32'(bus.valid), 0);

      // ch2: nine rises while stalled saturates at seven and flags overflow
      bus.ready = 1'b0;
      for (int r = 0; r < 9; r++) begin
         in_data[2] = 1'b0; cyc(1);
         in_data[2] = 1'b1; cyc(1);
      end
      cyc(5);
      chk("t3_ovf_set", 32'(overflow), 'h04);
      chk("t3_stall_valid", 32'(bus.valid), 1);
      chk("t3_stall_idx", 32'(bus.index), 2);
      bus.ready = 1'b1;
      count_valid(12, 3'd2, hits, any);
      chk("t3_transfers_ch2", 32'(hits), 7);
      chk("t3_transfers_all", 32'(any), 7);
      chk("t3_ovf_sticky", 32'(overflow), 'h04);
      clr_overflow = 1'b1; cyc(1); clr_overflow = 1'b0;
      chk("t3_ovf_cleared", 32'(overflow), 0);

      // both-edge mode: a 3-cycle pulse gives two events, mode 00 gives none
      edge_mode = 2'b11;
      in_data[0] = 1'b1; cyc(3); in_data[0] = 1'b0;
      count_valid(14, 3'd0, hits, any);
      chk("t4_both_ch0", 32'(hits), 2);
      chk("t4_both_all", 32'(any), 2);
      edge_mode = 2'b00;
      in_data[0] = 1'b1; cyc(3); in_data[0] = 1'b0;
      count_valid(14, 3'd0, hits, any);
      chk("t4_mode00", 32'(any), 0);

      // disabled channel does not queue
      edge_mode = 2'b01; chan_en = 8'hFD;
      in_data[1] = 1'b0; cyc(2); in_data[1] = 1'b1;
      count_valid(8, 3'd1, hits, any);
      chk("chan_en_blocks", 32'(any), 0);
      chan_en = '1;

      // lines high through reset release give no events; a later ch4 rise gives one
      rstn = 1'b0; in_data = 8'hFF;
      cyc(2); rstn = 1'b1;
      count_valid(10, 3'd0, hits, any);
      chk("t5_warmup_quiet", 32'(any), 0);
      chk("t5_ovf", 32'(overflow), 0);
      in_data[4] = 1'b0; cyc(2); in_data[4] = 1'b1;
      count_valid(10, 3'd4, hits, any);
      chk("t5_ch4_idx", 32'(hits), 1);
      chk("t5_ch4_all", 32'(any), 1);

      // stall with other channels firing, then reset mid-stream
      bus.ready = 1'b0;
      in_data[4] = 1'b0; cyc(1); in_data[4] = 1'b1;
      cyc(5);
      chk("t6_hold_valid", 32'(bus.valid), 1);
      chk("t6_hold_idx", 32'(bus.index), 4);
      stable = 0;
      for (int r = 0; r < 9; r++) begin
         in_data = in_data & ~8'h83; cyc(1);
         if (bus.valid === 1'b1 && bus.index === 3'd4) stable++;
         in_data = in_data | 8'h83; cyc(1);
         if (bus.valid === 1'b1 && bus.index === 3'd4) stable++;
      end
      chk("t6_stable_cycles", 32'(stable), 18);
      cyc(4);
      chk("t6_ovf_multi", 32'(overflow), 'h83);
      chk("t6_still_idx", 32'(bus.index), 4);
      rstn = 1'b0;
      cyc(1);
      chk("t6_rst_valid", 32'(bus.valid), 0);
      chk("t6_rst_ovf", 32'(overflow), 0);
      chk("t6_rst_idx", 32'(bus.index), 0);
      rstn = 1'b1; bus.ready = 1'b1;
      count_valid(10, 3'd0, hits, any);
      chk("t6_pending_discarded", 32'(any), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
